axi_mux: RTL and testbench

//  Write-path AXI multiplexer: INPUT_NUM masters onto one slave port; inverse of axi_demux.

---
 rtl/axi_mux_pkg.sv | 46 ++++
 rtl/axi_mux_rr_arb.sv | 72 +++++++
 rtl/axi_mux.sv | 183 ++++++++++++++++++
 tb/tb_axi_mux.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mux_pkg.sv
// -----------------------------------------------------------------------------
// axi_mux_pkg
// Purpose : Shared AXI channel types and widths for the write-path AXI
//           multiplexer, plus a small round-robin helper.
// Contents: ID_W/ADDR_W/DATA_W/STRB_W widths, axi_mosi_t (master->slave),
//           axi_miso_t (slave->master), rr_next() pointer-wrap helper.
// -----------------------------------------------------------------------------
package axi_mux_pkg;

   localparam int unsigned ID_W   = 3;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   // Request direction: AW, W, B-ready, plus the (unused) read-side handshakes
   typedef struct packed {
      logic [ID_W-1:0]   aw_id;
      logic [ADDR_W-1:0] aw_addr;
      logic [7:0]        aw_len;
      logic              aw_valid;
      logic [DATA_W-1:0] w_data;
      logic [STRB_W-1:0] w_strb;
      logic              w_last;
      logic              w_valid;
      logic              b_ready;
      logic              ar_valid;
      logic              r_ready;
   } axi_mosi_t;

   // Response direction: AW/W readies, B response, (unused) read-side handshakes
   typedef struct packed {
      logic              aw_ready;
      logic              w_ready;
      logic [ID_W-1:0]   b_id;
      logic [1:0]        b_resp;
      logic              b_valid;
      logic              ar_ready;
      logic              r_valid;
   } axi_miso_t;

   // Next round-robin position after idx among n entries
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/axi_mux_rr_arb.sv
// -----------------------------------------------------------------------------
// axi_mux_rr_arb
// Purpose : Round-robin arbiter for the AW channel with grant lock.
//           Combinational pick starting at the rotating pointer; once a grant
//           is stalled downstream it is frozen until the handshake completes.
// Ports   : i_clk, i_rst_n   clock / async active-low reset
//           i_req            per-input AWVALID
//           i_hold           granted AW presented but not accepted this cycle
//           i_advance        granted AW handshake this cycle
//           o_valid          a grant exists
//           o_grant, o_idx   one-hot grant and its index
// -----------------------------------------------------------------------------
module axi_mux_rr_arb
   import axi_mux_pkg::*;
#(
   parameter int unsigned INPUT_NUM = 3
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [INPUT_NUM-1:0]         i_req,
   input  logic                         i_hold,
   input  logic                         i_advance,
   output logic                         o_valid,
   output logic [INPUT_NUM-1:0]         o_grant,
   output logic [$clog2(INPUT_NUM)-1:0] o_idx
);

   localparam int unsigned IDX_W = $clog2(INPUT_NUM);

   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] r_lock_idx;
   logic             r_lock;

   logic [IDX_W-1:0] w_pick;
   logic [IDX_W-1:0] w_cand;
   logic             w_found;

   always_comb begin
      w_pick  = r_ptr;
      w_cand  = r_ptr;
      w_found = 1'b0;
      for (int unsigned k = 0; k < INPUT_NUM; k++) begin
         w_cand = IDX_W'((32'(r_ptr) + k) % INPUT_NUM);
         if (!w_found && i_req[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   always_comb begin
      o_idx   = r_lock ? r_lock_idx : w_pick;
      o_valid = r_lock ? i_req[r_lock_idx] : w_found;
      o_grant = o_valid ? (INPUT_NUM'(1) << o_idx) : '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr      <= '0;
         r_lock     <= 1'b0;
         r_lock_idx <= '0;
      end else if (i_advance) begin
         r_ptr  <= IDX_W'(rr_next(32'(o_idx), INPUT_NUM));
         r_lock <= 1'b0;
      end else if (i_hold && !r_lock) begin
         // Freeze the grant so the presented AW stays stable until accepted
         r_lock     <= 1'b1;
         r_lock_idx <= o_idx;
      end
   end

endmodule

// File: rtl/axi_mux.sv
// -----------------------------------------------------------------------------
// axi_mux
// Purpose : Write-path AXI multiplexer, INPUT_NUM upstream masters onto one
//           downstream slave. AW is round-robin arbitrated (0-cycle pass-through),
//           W bursts follow AW grant order via a grant-order FIFO, B is routed
//           back by BID range. AR/R are not supported (ARREADY=0, RVALID=0).
// Ports   : ACLK, ARESETn       clock / async active-low reset
//           s_axi_i, s_axi_o    upstream master requests / responses
//           m_axi_i, m_axi_o    downstream slave responses / merged request
//           pmu_aw_cnt_o        per-input AW handshake counters (32b each)
//           pmu_stall_o         cycles an AW was blocked by a full FIFO
// Config  : AXI_MUX_PMU_EN adds the pmu_* ports and counters; datapath is
//           identical with or without it.
// -----------------------------------------------------------------------------
module axi_mux
   import axi_mux_pkg::*;
#(
   parameter int unsigned INPUT_NUM                   = 3,
   parameter int unsigned ID_ROUTING [INPUT_NUM+1]    = '{0, 1, 2, 3},
   parameter int unsigned W_FIFO_DEPTH                = 4
) (
   input  logic                       ACLK,
   input  logic                       ARESETn,
   input  axi_mosi_t                  s_axi_i [INPUT_NUM],
   output axi_miso_t                  s_axi_o [INPUT_NUM],
   input  axi_miso_t                  m_axi_i,
`ifdef AXI_MUX_PMU_EN
   output logic [32*INPUT_NUM-1:0]    pmu_aw_cnt_o,
   output logic [31:0]                pmu_stall_o,
`endif
   output axi_mosi_t                  m_axi_o
);

   localparam int unsigned IDX_W = $clog2(INPUT_NUM);
   localparam int unsigned PTR_W = $clog2(W_FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [INPUT_NUM-1:0] w_aw_req;
   logic [INPUT_NUM-1:0] w_aw_grant;
   logic [IDX_W-1:0]     w_aw_idx;
   logic                 w_aw_any;
   logic                 w_aw_hold;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [IDX_W-1:0]     w_head;
   logic [IDX_W-1:0]     w_b_idx;
   logic                 w_b_hit;
   logic                 w_unused;

   logic [IDX_W-1:0]     r_fifo [W_FIFO_DEPTH];
   logic [PTR_W-1:0]     r_wptr;
   logic [PTR_W-1:0]     r_rptr;
   logic [CNT_W-1:0]     r_count;

   always_comb begin
      for (int i = 0; i < INPUT_NUM; i++) begin
         w_aw_req[i] = s_axi_i[i].aw_valid;
      end
   end

   axi_mux_rr_arb #(
      .INPUT_NUM (INPUT_NUM)
   ) u_arb (
      .i_clk     (ACLK),
      .i_rst_n   (ARESETn),
      .i_req     (w_aw_req),
      .i_hold    (w_aw_hold),
      .i_advance (w_push),
      .o_valid   (w_aw_any),
      .o_grant   (w_aw_grant),
      .o_idx     (w_aw_idx)
   );

   assign w_fifo_full  = (r_count == CNT_W'(W_FIFO_DEPTH));
   assign w_fifo_empty = (r_count == '0);
   assign w_head       = r_fifo[r_rptr];

   // First matching ID range wins; no match means the B beat is sunk here
   always_comb begin
      w_b_hit = 1'b0;
      w_b_idx = '0;
      for (int i = 0; i < INPUT_NUM; i++) begin
         if (!w_b_hit && (32'(m_axi_i.b_id) >= ID_ROUTING[i]) &&
             (32'(m_axi_i.b_id) < ID_ROUTING[i+1])) begin
            w_b_hit = 1'b1;
            w_b_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      m_axi_o          = '0;
      // A full FIFO blocks AW outright, even if a pop happens this cycle
      m_axi_o.aw_valid = w_aw_any && !w_fifo_full;
      m_axi_o.aw_id    = s_axi_i[w_aw_idx].aw_id;
      m_axi_o.aw_addr  = s_axi_i[w_aw_idx].aw_addr;
      m_axi_o.aw_len   = s_axi_i[w_aw_idx].aw_len;
      m_axi_o.w_valid  = !w_fifo_empty && s_axi_i[w_head].w_valid;
      m_axi_o.w_data   = s_axi_i[w_head].w_data;
      m_axi_o.w_strb   = s_axi_i[w_head].w_strb;
      m_axi_o.w_last   = s_axi_i[w_head].w_last;
      m_axi_o.b_ready  = w_b_hit ? s_axi_i[w_b_idx].b_ready : 1'b1;
   end

   always_comb begin
      for (int i = 0; i < INPUT_NUM; i++) begin
         s_axi_o[i]          = '0;
         s_axi_o[i].aw_ready = w_aw_grant[i] && !w_fifo_full && m_axi_i.aw_ready;
         s_axi_o[i].w_ready  = !w_fifo_empty && (w_head == IDX_W'(i)) && m_axi_i.w_ready;
         s_axi_o[i].b_id     = m_axi_i.b_id;
         s_axi_o[i].b_resp   = m_axi_i.b_resp;
         s_axi_o[i].b_valid  = w_b_hit && (w_b_idx == IDX_W'(i)) && m_axi_i.b_valid;
      end
   end

   assign w_push    = m_axi_o.aw_valid && m_axi_i.aw_ready;
   assign w_aw_hold = m_axi_o.aw_valid && !m_axi_i.aw_ready;
   assign w_pop     = m_axi_o.w_valid && m_axi_i.w_ready && m_axi_o.w_last;

   // Grant-order FIFO: one entry per accepted AW whose W burst is not done
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < W_FIFO_DEPTH; i++) begin
            r_fifo[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_fifo[r_wptr] <= w_aw_idx;
            r_wptr         <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef AXI_MUX_PMU_EN
   logic [31:0] r_pmu_aw [INPUT_NUM];
   logic [31:0] r_pmu_stall;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_pmu_stall <= '0;
         for (int i = 0; i < INPUT_NUM; i++) begin
            r_pmu_aw[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_pmu_aw[w_aw_idx] <= r_pmu_aw[w_aw_idx] + 32'd1;
         end
         if (w_aw_any && w_fifo_full) begin
            r_pmu_stall <= r_pmu_stall + 32'd1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < INPUT_NUM; i++) begin
         pmu_aw_cnt_o[32*i +: 32] = r_pmu_aw[i];
      end
      pmu_stall_o = r_pmu_stall;
   end
`endif

   // Read-side handshakes are accepted on the ports but intentionally ignored
   always_comb begin
      w_unused = m_axi_i.ar_ready ^ m_axi_i.r_valid;
      for (int i = 0; i < INPUT_NUM; i++) begin
         w_unused = w_unused ^ s_axi_i[i].ar_valid ^ s_axi_i[i].r_ready;
      end
   end

endmodule

// File: tb/tb_axi_mux.sv
// -----------------------------------------------------------------------------
// tb_axi_mux
// Purpose : Self-checking bench for axi_mux (INPUT_NUM=3, ID_ROUTING 0..3,
//           W_FIFO_DEPTH=4). Directed stimulus pushes expected AW/W/B traffic
//           into queues; a negedge monitor pops and compares on every
//           downstream AW/W handshake and every upstream B handshake.
// -----------------------------------------------------------------------------
module tb_axi_mux;
   import axi_mux_pkg::*;

   logic      ACLK;
   logic      ARESETn;
   axi_mosi_t s_req [3];
   axi_miso_t s_rsp [3];
   axi_miso_t m_rsp;
   axi_mosi_t m_req;
`ifdef AXI_MUX_PMU_EN
   logic [95:0] pmu_aw_cnt;
   logic [31:0] pmu_stall;
`endif

   int checks;
   int failures;

   logic [18:0] q_aw [$];   // {id, addr}
   logic [32:0] q_w  [$];   // {last, data}
   logic [4:0]  q_b  [$];   // {port, id}

   logic [18:0] mon_aw;
   logic [32:0] mon_w;
   logic [4:0]  mon_b;

   axi_mux #(
      .INPUT_NUM    (3),
      .ID_ROUTING   ('{0, 1, 2, 3}),
      .W_FIFO_DEPTH (4)
   ) dut (
      .ACLK         (ACLK),
      .ARESETn      (ARESETn),
      .s_axi_i      (s_req),
      .s_axi_o      (s_rsp),
      .m_axi_i      (m_rsp),
`ifdef AXI_MUX_PMU_EN
      .pmu_aw_cnt_o (pmu_aw_cnt),
      .pmu_stall_o  (pmu_stall),
`endif
      .m_axi_o      (m_req)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #200000;
      $display("FAIL watchdog: actual=time limit reached required=bench completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic report_fail(input string name, input int port);
      checks++;
      failures++;
      $display("FAIL %s: actual=no handshake on port %0d required=handshake", name, port);
   endtask

   // Scoreboard monitor
   always @(negedge ACLK) begin
      if (ARESETn) begin
         if (m_req.aw_valid && m_rsp.aw_ready) begin
            if (q_aw.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL m_aw_unexpected: actual=%0h required=none", m_req.aw_addr);
            end else begin
               mon_aw = q_aw.pop_front();
               check("m_aw", {m_req.aw_id, m_req.aw_addr}, mon_aw);
            end
         end
         if (m_req.w_valid && m_rsp.w_ready) begin
            if (q_w.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL m_w_unexpected: actual=%0h required=none", m_req.w_data);
            end else begin
               mon_w = q_w.pop_front();
               check("m_w", {m_req.w_last, m_req.w_data}, mon_w);
            end
         end
         for (int i = 0; i < 3; i++) begin
            if (s_rsp[i].b_valid && s_req[i].b_ready) begin
               if (q_b.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL s_b_unexpected: actual=port %0d required=none", i);
               end else begin
                  mon_b = q_b.pop_front();
                  check("s_b", {2'(i), s_rsp[i].b_id}, mon_b);
               end
            end
         end
      end
   end

   task automatic push_w(input int i, input int n, input logic [7:0] tag);
      for (int b = 0; b < n; b++) begin
         q_w.push_back({(b == n - 1), 8'(i), tag, 16'(b)});
      end
   endtask

   task automatic aw_issue(input int i, input logic [2:0] id, input logic [15:0] addr,
                           input logic [7:0] len);
      s_req[i].aw_id    = id;
      s_req[i].aw_addr  = addr;
      s_req[i].aw_len   = len;
      s_req[i].aw_valid = 1'b1;
   endtask

   task automatic aw_wait(input int i);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge ACLK);
         if (s_rsp[i].aw_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) report_fail("aw_timeout", i);
      @(posedge ACLK);
      #1;
      s_req[i].aw_valid = 1'b0;
   endtask

   task automatic w_burst(input int i, input int n, input logic [7:0] tag);
      bit ok;
      for (int b = 0; b < n; b++) begin
         s_req[i].w_data  = {8'(i), tag, 16'(b)};
         s_req[i].w_strb  = '1;
         s_req[i].w_last  = (b == n - 1);
         s_req[i].w_valid = 1'b1;
         ok = 1'b0;
         for (int k = 0; k < 40; k++) begin
            @(negedge ACLK);
            if (s_rsp[i].w_ready) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) report_fail("w_timeout", i);
         @(posedge ACLK);
         #1;
      end
      s_req[i].w_valid = 1'b0;
      s_req[i].w_last  = 1'b0;
   endtask

   task automatic do_reset();
      ARESETn = 1'b0;
      for (int i = 0; i < 3; i++) s_req[i] = '0;
      m_rsp = '0;
      repeat (2) @(posedge ACLK);
      #1;
      check("rst_s_awready", {s_rsp[0].aw_ready, s_rsp[1].aw_ready, s_rsp[2].aw_ready}, 0);
      check("rst_s_wready", {s_rsp[0].w_ready, s_rsp[1].w_ready, s_rsp[2].w_ready}, 0);
      check("rst_s_bvalid", {s_rsp[0].b_valid, s_rsp[1].b_valid, s_rsp[2].b_valid}, 0);
      check("rst_m_valid_bready", {m_req.aw_valid, m_req.w_valid, m_req.b_ready}, 0);
      ARESETn = 1'b1;
      @(posedge ACLK);
      #1;
      for (int i = 0; i < 3; i++) s_req[i].b_ready = 1'b1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      do_reset();

      // 1: single burst on input 1, B routed back to input 1
      m_rsp.aw_ready = 1'b1;
      m_rsp.w_ready  = 1'b1;
      q_aw.push_back({3'd1, 16'h0100});
      push_w(1, 2, 8'h11);
      aw_issue(1, 3'd1, 16'h0100, 8'd1);
      #2;
      check("t1_aw_passthru_valid", m_req.aw_valid, 1);
      check("t1_aw_passthru_id", m_req.aw_id, 1);
      aw_wait(1);
      w_burst(1, 2, 8'h11);
      q_b.push_back({2'd1, 3'd1});
      m_rsp.b_id    = 3'd1;
      m_rsp.b_valid = 1'b1;
      #2;
      check("t1_b_other_ports", {s_rsp[0].b_valid, s_rsp[2].b_valid}, 0);
      check("t1_m_bready", m_req.b_ready, 1);
      @(posedge ACLK);
      #1;
      s_req[1].b_ready = 1'b0;
      #1;
      check("t1_m_bready_follows_owner", m_req.b_ready, 0);
      check("t1_s1_bvalid", s_rsp[1].b_valid, 1);
      m_rsp.b_valid    = 1'b0;
      s_req[1].b_ready = 1'b1;

      // 2: contention from pointer 0, W bursts must come out in grant order
      do_reset();
      m_rsp.aw_ready = 1'b1;
      m_rsp.w_ready  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         q_aw.push_back({3'(i), 16'h0200 + 16'(i)});
         push_w(i, 2, 8'h20 + 8'(i));
      end
      for (int i = 0; i < 3; i++) aw_issue(i, 3'(i), 16'h0200 + 16'(i), 8'd1);
      aw_wait(0);
      aw_wait(1);
      aw_wait(2);
      fork
         w_burst(2, 2, 8'h22);
         w_burst(1, 2, 8'h21);
         w_burst(0, 2, 8'h20);
      join
`ifdef AXI_MUX_PMU_EN
      check("t2_pmu_aw0", pmu_aw_cnt[31:0], 1);
      check("t2_pmu_aw1", pmu_aw_cnt[63:32], 1);
      check("t2_pmu_aw2", pmu_aw_cnt[95:64], 1);
`endif

      // 3: stalled AW stays locked on input 0 although rr would now pick input 2
      q_aw.push_back({3'd0, 16'h0300});
      push_w(0, 1, 8'h30);
      aw_issue(0, 3'd0, 16'h0300, 8'd0);
      aw_wait(0);
      w_burst(0, 1, 8'h30);
      m_rsp.aw_ready = 1'b0;
      q_aw.push_back({3'd0, 16'h0310});
      q_aw.push_back({3'd2, 16'h0320});
      push_w(0, 1, 8'h31);
      push_w(2, 1, 8'h32);
      aw_issue(0, 3'd0, 16'h0310, 8'd0);
      @(posedge ACLK);
      #1;
      aw_issue(2, 3'd2, 16'h0320, 8'd0);
      repeat (3) begin
         @(negedge ACLK);
         check("t3_stall_aw", {m_req.aw_valid, m_req.aw_id, m_req.aw_addr},
               {1'b1, 3'd0, 16'h0310});
      end
      @(posedge ACLK);
      #1;
      m_rsp.aw_ready = 1'b1;
      aw_wait(0);
      aw_wait(2);
      fork
         w_burst(2, 1, 8'h32);
         w_burst(0, 1, 8'h31);
      join

      // 4: four AWs fill the FIFO, the fifth waits for the first WLAST
      m_rsp.w_ready = 1'b0;
      q_aw.push_back({3'd0, 16'h0400});
      q_aw.push_back({3'd1, 16'h0410});
      q_aw.push_back({3'd2, 16'h0420});
      q_aw.push_back({3'd0, 16'h0430});
      q_aw.push_back({3'd1, 16'h0440});
      push_w(0, 1, 8'h40);
      push_w(1, 1, 8'h41);
      push_w(2, 1, 8'h42);
      push_w(0, 1, 8'h43);
      push_w(1, 1, 8'h44);
      aw_issue(0, 3'd0, 16'h0400, 8'd0);
      aw_wait(0);
      aw_issue(1, 3'd1, 16'h0410, 8'd0);
      aw_wait(1);
      aw_issue(2, 3'd2, 16'h0420, 8'd0);
      aw_wait(2);
      aw_issue(0, 3'd0, 16'h0430, 8'd0);
      aw_wait(0);
      aw_issue(1, 3'd1, 16'h0440, 8'd0);
      repeat (3) begin
         @(negedge ACLK);
         check("t4_full_blocks_aw", {s_rsp[1].aw_ready, m_req.aw_valid}, 0);
      end
      @(posedge ACLK);
      #1;
      m_rsp.w_ready = 1'b1;
      fork
         w_burst(0, 1, 8'h40);
         aw_wait(1);
      join
`ifdef AXI_MUX_PMU_EN
      check("t4_pmu_stall", pmu_stall, 4);
`endif
      w_burst(1, 1, 8'h41);
      w_burst(2, 1, 8'h42);
      w_burst(0, 1, 8'h43);
      w_burst(1, 1, 8'h44);

      // 5: W presented ahead of its AW is held upstream
      q_aw.push_back({3'd2, 16'h0500});
      push_w(2, 1, 8'h50);
      s_req[2].w_data  = {8'd2, 8'h50, 16'd0};
      s_req[2].w_strb  = '1;
      s_req[2].w_last  = 1'b1;
      s_req[2].w_valid = 1'b1;
      repeat (2) begin
         @(negedge ACLK);
         check("t5_early_w_held", {s_rsp[2].w_ready, m_req.w_valid}, 0);
      end
      @(posedge ACLK);
      #1;
      aw_issue(2, 3'd2, 16'h0500, 8'd0);
      #2;
      check("t5_w_held_during_aw", s_rsp[2].w_ready, 0);
      aw_wait(2);
      w_burst(2, 1, 8'h50);

      // 6: out-of-range BID is sunk; in-range BID follows the owner's BREADY
      for (int i = 0; i < 3; i++) s_req[i].b_ready = 1'b0;
      @(posedge ACLK);
      #1;
      m_rsp.b_id    = 3'd7;
      m_rsp.b_valid = 1'b1;
      #1;
      check("t6_bad_bid_bready", m_req.b_ready, 1);
      check("t6_bad_bid_no_bvalid",
            {s_rsp[0].b_valid, s_rsp[1].b_valid, s_rsp[2].b_valid}, 0);
      m_rsp.b_id = 3'd3;
      #1;
      check("t6_bid_upper_bound_drop", {m_req.b_ready, s_rsp[2].b_valid}, {1'b1, 1'b0});
      m_rsp.b_id = 3'd2;
      #1;
      check("t6_bid2_route", {m_req.b_ready, s_rsp[2].b_valid, s_rsp[0].b_valid},
            {1'b0, 1'b1, 1'b0});
      m_rsp.b_valid = 1'b0;

      repeat (5) @(posedge ACLK);
      #1;
      check("end_q_aw_empty", q_aw.size(), 0);
      check("end_q_w_empty", q_w.size(), 0);
      check("end_q_b_empty", q_b.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
